// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational 16-bit ALU between two requesters.
//
// Round-robin arbitration between requester 0 (execute stage) and
// requester 1 (address/branch-compare unit). The granted requester's
// operands drive the ALU in the same cycle. The ALU result and flags are
// captured into a one-entry response slot tagged with the requester ID.
// An architectural SZCV flag register is updated by flag-setting ops.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   reqN_valid/ready           per-requester handshake (ready = grant, combinational)
//   reqN_a/b/op                per-requester operands and op code
//   reqN_lock                  lock request (only with ALU_LOCK_EN)
//   alu_inA/inB/op             drive to the external ALU (combinational)
//   alu_out/alu_SZCV           ALU result and {S,Z,C,V} flags
//   rsp_valid/ready            response slot handshake
//   rsp_id/data/szcv           registered response payload
//   flags                      architectural SZCV flag register
//
// Optional build macro: ALU_LOCK_EN adds req0_lock/req1_lock so that a
// requester can hold the ALU for an atomic multi-op sequence.

module alu_arbiter #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned OP_W   = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [DATA_W-1:0] req0_a,
   input  logic [DATA_W-1:0] req0_b,
   input  logic [OP_W-1:0]   req0_op,
`ifdef ALU_LOCK_EN
   input  logic              req0_lock,
`endif
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [DATA_W-1:0] req1_a,
   input  logic [DATA_W-1:0] req1_b,
   input  logic [OP_W-1:0]   req1_op,
`ifdef ALU_LOCK_EN
   input  logic              req1_lock,
`endif
   output logic [DATA_W-1:0] alu_inA,
   output logic [DATA_W-1:0] alu_inB,
   output logic [OP_W-1:0]   alu_op,
   input  logic [DATA_W-1:0] alu_out,
   input  logic [3:0]        alu_SZCV,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic              rsp_id,
   output logic [DATA_W-1:0] rsp_data,
   output logic [3:0]        rsp_szcv,
   output logic [3:0]        flags
);

   localparam int unsigned FLAG_W = 4;
   // Ops 0..6 (ADD, SUB, AND, OR, XOR, CMP, MOV) update the flag register.
   localparam logic [OP_W-1:0] LAST_FLAG_OP = OP_W'(6);

   typedef enum logic [0:0] {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic            ptr;
   logic            can_issue;
   logic            elig0;
   logic            elig1;
   logic            grant0;
   logic            grant1;
   logic            grant_any;
   logic            ptr_adv;
   logic [OP_W-1:0] grant_op;

`ifdef ALU_LOCK_EN
   logic lock_active;
   logic lock_owner;

   // While locked, only the lock owner is eligible.
   assign elig0   = req0_valid & ~(lock_active &  lock_owner);
   assign elig1   = req1_valid & ~(lock_active & ~lock_owner);
   // A grant that keeps (or takes) the lock freezes the pointer.
   assign ptr_adv = ~(grant1 ? req1_lock : req0_lock);

   // Lock state follows the lock bit of every grant.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         lock_active <= 1'b0;
         lock_owner  <= 1'b0;
      end else if (grant_any) begin
         lock_active <= ~ptr_adv;
         lock_owner  <= grant1;
      end
   end
`else
   assign elig0   = req0_valid;
   assign elig1   = req1_valid;
   assign ptr_adv = 1'b1;
`endif

   // Arbitration: a single eligible requester wins; on contention the pointer decides.
   always_comb begin
      can_issue = rst_n & ((state == ST_EMPTY) | rsp_ready);
      grant0    = can_issue & elig0 & (~elig1 | ~ptr);
      grant1    = can_issue & elig1 & (~elig0 |  ptr);
      grant_any = grant0 | grant1;
   end

   assign req0_ready = grant0;
   assign req1_ready = grant1;

   // ALU mux defaults to requester 0 when nothing is granted.
   assign alu_inA  = grant1 ? req1_a  : req0_a;
   assign alu_inB  = grant1 ? req1_b  : req0_b;
   assign alu_op   = grant1 ? req1_op : req0_op;
   assign grant_op = alu_op;

   // Response slot state register.
   always_ff @(posedge clk) begin
      if (!rst_n) state <= ST_EMPTY;
      else        state <= state_nxt;
   end

   // Response slot next state; a grant during drain refills without a bubble.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_EMPTY: if (grant_any) state_nxt = ST_FULL;
         ST_FULL: begin
            if (grant_any)      state_nxt = ST_FULL;
            else if (rsp_ready) state_nxt = ST_EMPTY;
         end
         default: state_nxt = ST_EMPTY;
      endcase
   end

   assign rsp_valid = (state == ST_FULL);

   // Response payload, flag register and round-robin pointer.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rsp_id   <= 1'b0;
         rsp_data <= '0;
         rsp_szcv <= '0;
         flags    <= '0;
         ptr      <= 1'b0;
      end else if (grant_any) begin
         rsp_id   <= grant1;
         rsp_data <= alu_out;
         rsp_szcv <= alu_SZCV[FLAG_W-1:0];
         if (grant_op <= LAST_FLAG_OP) flags <= alu_SZCV[FLAG_W-1:0];
         // Pointer moves to the requester that was not granted.
         if (ptr_adv) ptr <= grant0;
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios with literal
// expectations plus randomized traffic compared every cycle against a
// transaction-level reference model.

module tb_alu_arbiter;

   localparam int unsigned DW = 16;
   localparam int unsigned OW = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          req0_valid, req1_valid;
   logic          req0_ready, req1_ready;
   logic [DW-1:0] req0_a, req0_b, req1_a, req1_b;
   logic [OW-1:0] req0_op, req1_op;
`ifdef ALU_LOCK_EN
   logic          req0_lock, req1_lock;
`endif
   logic [DW-1:0] alu_inA, alu_inB, alu_out;
   logic [OW-1:0] alu_op;
   logic [3:0]    alu_SZCV;
   logic          rsp_valid, rsp_ready, rsp_id;
   logic [DW-1:0] rsp_data;
   logic [3:0]    rsp_szcv, flags;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   alu_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready),
      .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
`ifdef ALU_LOCK_EN
      .req0_lock(req0_lock),
`endif
      .req1_valid(req1_valid), .req1_ready(req1_ready),
      .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
`ifdef ALU_LOCK_EN
      .req1_lock(req1_lock),
`endif
      .alu_inA(alu_inA), .alu_inB(alu_inB), .alu_op(alu_op),
      .alu_out(alu_out), .alu_SZCV(alu_SZCV),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_data(rsp_data), .rsp_szcv(rsp_szcv), .flags(flags)
   );

   // Reference ALU: returns {S,Z,C,V,result}; C is borrow for SUB/CMP.
   function automatic logic [19:0] alu_f(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
      logic [16:0] s;
      logic [15:0] r;
      logic c, v;
      c = 1'b0; v = 1'b0; r = 16'h0; s = 17'h0;
      case (op)
         4'd0: begin
            s = {1'b0, a} + {1'b0, b};
            r = s[15:0]; c = s[16];
            v = (a[15] == b[15]) && (r[15] != a[15]);
         end
         4'd1, 4'd5: begin
            r = a - b; c = (a < b);
            v = (a[15] != b[15]) && (r[15] != a[15]);
         end
         4'd2: r = a & b;
         4'd3: r = a | b;
         4'd4: r = a ^ b;
         4'd6: r = b;
         default: return 20'h0;
      endcase
      return {r[15], (r == 16'h0), c, v, r};
   endfunction

   assign {alu_SZCV, alu_out} = alu_f(alu_op, alu_inA, alu_inB);

   // Transaction-level model state.
   logic          m_ok = 1'b0;
   logic          m_full, m_id, m_prefer;
   logic [15:0]   m_data;
   logic [3:0]    m_szcv, m_flags;
   int            last_g = -1;
`ifdef ALU_LOCK_EN
   logic          m_lock_act, m_lock_own;
`endif

   // Which requester must be granted right now: -1 none, 0 or 1.
   function automatic int exp_grant();
      logic e0, e1;
      if (!rst_n) return -1;
      if (m_full && !rsp_ready) return -1;
      e0 = req0_valid; e1 = req1_valid;
`ifdef ALU_LOCK_EN
      if (m_lock_act) begin
         if (m_lock_own) e0 = 1'b0;
         else            e1 = 1'b0;
      end
`endif
      if (e0 && e1) return m_prefer ? 1 : 0;
      if (e0) return 0;
      if (e1) return 1;
      return -1;
   endfunction

   task automatic model_update();
      int g;
      logic [19:0] r;
      logic [3:0] op;
      logic lk;
      if (!rst_n) begin
         m_ok = 1'b1; m_full = 1'b0; m_id = 1'b0; m_prefer = 1'b0;
         m_data = 16'h0; m_szcv = 4'h0; m_flags = 4'h0; last_g = -1;
`ifdef ALU_LOCK_EN
         m_lock_act = 1'b0; m_lock_own = 1'b0;
`endif
      end else if (m_ok) begin
         g = exp_grant();
         if (g >= 0) begin
            op = (g == 1) ? req1_op : req0_op;
            r  = (g == 1) ? alu_f(req1_op, req1_a, req1_b) : alu_f(req0_op, req0_a, req0_b);
            m_full = 1'b1; m_id = (g == 1); m_data = r[15:0]; m_szcv = r[19:16];
            if (op <= 4'd6) m_flags = r[19:16];
            lk = 1'b0;
`ifdef ALU_LOCK_EN
            lk = (g == 1) ? req1_lock : req0_lock;
            m_lock_act = lk; m_lock_own = (g == 1);
`endif
            if (!lk) m_prefer = (g == 0);
         end else if (rsp_ready) begin
            m_full = 1'b0;
         end
         last_g = g;
      end
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison of every DUT output against the model.
   always @(negedge clk) begin
      int g;
      if (m_ok) begin
         g = exp_grant();
         check("req0_ready", 32'(req0_ready), 32'(g == 0));
         check("req1_ready", 32'(req1_ready), 32'(g == 1));
         check("alu_inA", 32'(alu_inA), 32'((g == 1) ? req1_a : req0_a));
         check("alu_inB", 32'(alu_inB), 32'((g == 1) ? req1_b : req0_b));
         check("alu_op", 32'(alu_op), 32'((g == 1) ? req1_op : req0_op));
         check("rsp_valid", 32'(rsp_valid), 32'(m_full));
         check("rsp_id", 32'(rsp_id), 32'(m_id));
         check("rsp_data", 32'(rsp_data), 32'(m_data));
         check("rsp_szcv", 32'(rsp_szcv), 32'(m_szcv));
         check("flags", 32'(flags), 32'(m_flags));
      end
   end

   task automatic tick();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic idle_reqs();
      req0_valid = 1'b0; req1_valid = 1'b0;
`ifdef ALU_LOCK_EN
      req0_lock = 1'b0; req1_lock = 1'b0;
`endif
   endtask

   task automatic do_reset();
      rst_n = 1'b0; idle_reqs(); rsp_ready = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   task automatic set0(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
      req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
   endtask

   task automatic set1(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
      req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
   endtask

   initial begin
      rst_n = 1'b0; rsp_ready = 1'b0; idle_reqs();
      req0_a = '0; req0_b = '0; req0_op = '0;
      req1_a = '0; req1_b = '0; req1_op = '0;

      // Reset state and single ADD with overflow.
      do_reset();
      check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
      check("reset_flags", 32'(flags), 32'd0);
      set0(4'd0, 16'h7FFF, 16'h0001); rsp_ready = 1'b1;
      #1 check("t1_ready", 32'(req0_ready), 32'd1);
      tick(); idle_reqs();
      check("t1_rsp_valid", 32'(rsp_valid), 32'd1);
      check("t1_rsp_id", 32'(rsp_id), 32'd0);
      check("t1_rsp_data", 32'(rsp_data), 32'h8000);
      check("t1_rsp_szcv", 32'(rsp_szcv), 32'h9);
      check("t1_flags", 32'(flags), 32'h9);

      // Contention: strict alternation 0,1,0,1.
      do_reset();
      set0(4'd1, 16'd5, 16'd5); set1(4'd3, 16'h00F0, 16'h0F00); rsp_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1 check("t2_grant", 32'((i % 2) ? req1_ready : req0_ready), 32'd1);
         tick();
         check("t2_rsp_id", 32'(rsp_id), 32'(i % 2));
         check("t2_rsp_data", 32'(rsp_data), (i % 2) ? 32'h0FF0 : 32'h0);
         check("t2_rsp_szcv", 32'(rsp_szcv), (i % 2) ? 32'h0 : 32'h4);
      end
      idle_reqs();

      // Backpressure hold, then back-to-back refill in the drain cycle.
      do_reset();
      set1(4'd0, 16'd1, 16'd1); rsp_ready = 1'b0;
      tick();
      repeat (3) begin
         check("t3_hold_valid", 32'(rsp_valid), 32'd1);
         check("t3_hold_data", 32'(rsp_data), 32'h2);
         check("t3_no_ready", 32'(req1_ready), 32'd0);
         tick();
      end
      rsp_ready = 1'b1;
      #1 check("t3_drain_grant", 32'(req1_ready), 32'd1);
      tick(); idle_reqs();
      check("t3_b2b_valid", 32'(rsp_valid), 32'd1);
      tick();
      check("t3_empty", 32'(rsp_valid), 32'd0);

      // CMP sets flags; op 1000 leaves them alone.
      do_reset();
      set0(4'd5, 16'd3, 16'd3); rsp_ready = 1'b1;
      tick();
      check("t4_cmp_flags", 32'(flags), 32'h4);
      set0(4'd8, 16'd3, 16'd3);
      tick(); idle_reqs();
      check("t4_op8_data", 32'(rsp_data), 32'h0);
      check("t4_op8_flags", 32'(flags), 32'h4);

      // Reset while FULL discards the response and restarts the pointer.
      do_reset();
      set1(4'd0, 16'd1, 16'd1); rsp_ready = 1'b0;
      tick(); idle_reqs();
      set0(4'd0, 16'd1, 16'd1);
      rst_n = 1'b0;
      #1 check("t5_no_grant_in_reset", 32'(req0_ready), 32'd0);
      tick();
      rst_n = 1'b1;
      check("t5_rsp_valid", 32'(rsp_valid), 32'd0);
      check("t5_flags", 32'(flags), 32'd0);
      set1(4'd2, 16'hFFFF, 16'h00FF); rsp_ready = 1'b1;
      #1 check("t5_req0_first", 32'(req0_ready), 32'd1);
      check("t5_req1_wait", 32'(req1_ready), 32'd0);
      tick(); idle_reqs();

`ifdef ALU_LOCK_EN
      // req1 holds the ALU for three ops while req0 waits.
      do_reset();
      rsp_ready = 1'b1;
      set1(4'd2, 16'h1234, 16'h00FF); req1_lock = 1'b1;
      #1 check("t6_lock_grant0", 32'(req1_ready), 32'd1);
      tick();
      set0(4'd0, 16'd2, 16'd3);
      for (int i = 1; i < 3; i++) begin
         req1_lock = (i < 2);
         #1 check("t6_lock_grant", 32'(req1_ready), 32'd1);
         check("t6_lock_block", 32'(req0_ready), 32'd0);
         tick();
      end
      req1_lock = 1'b0;
      #1 check("t6_release", 32'(req0_ready), 32'd1);
      tick(); idle_reqs();
`endif

      // Randomized traffic with random backpressure and occasional reset.
      do_reset();
      for (int c = 0; c < 4000; c++) begin
         if (!req0_valid || last_g == 0) begin
            req0_valid = ($urandom_range(0, 3) != 0);
            req0_a = 16'($urandom); req0_b = 16'($urandom);
            req0_op = 4'($urandom_range(0, 15));
`ifdef ALU_LOCK_EN
            req0_lock = ($urandom_range(0, 3) == 0);
`endif
         end
         if (!req1_valid || last_g == 1) begin
            req1_valid = ($urandom_range(0, 3) != 0);
            req1_a = 16'($urandom); req1_b = 16'($urandom);
            req1_op = 4'($urandom_range(0, 15));
`ifdef ALU_LOCK_EN
            req1_lock = ($urandom_range(0, 3) == 0);
`endif
         end
         rsp_ready = ($urandom_range(0, 9) < 7);
         rst_n = ($urandom_range(0, 299) != 0);
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
